// File: rtl/flush_redirect_ctrl_pkg.sv
// flush_redirect_ctrl shared types
// front-end flush/redirect sequencer package
package flush_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } fr_state_e;

  localparam int MAX_OUTST_DEF = 2;
  localparam int CNT_W_DEF     = 2;

endpackage

// File: rtl/flush_redirect_ctrl.sv
// flush_redirect_ctrl: flush, drain stale
// inst responses, then redirect IF
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             excp_flush,
  input  logic             ertn_flush,
  input  logic [31:0]      eentry,
  input  logic [31:0]      era,
  input  logic             if_req_fire,
  input  logic             if_resp_fire,
  output logic             flush,
  output logic             if_block,
  output logic             resp_discard,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic             busy,
  output logic [CNT_W-1:0] outst_cnt
);

  fr_state_e        state, state_nxt;
  logic [CNT_W-1:0] outst_q, outst_nxt;
  logic [CNT_W-1:0] disc_q, disc_nxt;
  logic [31:0]      target_q, target_nxt;
  logic [CNT_W:0]   sum;
  logic             ev;

  assign ev = (excp_flush | ertn_flush)
            & (state == ST_IDLE) & ~reset;

  // outstanding count, clamped to [0, MAX_OUTST]
  always_comb begin
    sum = {1'b0, outst_q} + (CNT_W+1)'(if_req_fire);
    if (if_resp_fire && sum != '0)
      sum = sum - (CNT_W+1)'(1);
    if (sum > (CNT_W+1)'(MAX_OUTST))
      sum = (CNT_W+1)'(MAX_OUTST);
    outst_nxt = sum[CNT_W-1:0];
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt      = state;
    disc_nxt       = disc_q;
    target_nxt     = target_q;
    flush          = 1'b0;
    if_block       = 1'b0;
    resp_discard   = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ev) begin
          flush      = 1'b1;
          target_nxt = excp_flush ? eentry : era;
          disc_nxt   = outst_nxt;
          state_nxt  = (outst_nxt != '0)
                     ? ST_DRAIN : ST_REDIRECT;
        end
      end
      ST_DRAIN: begin
        if_block     = 1'b1;
        resp_discard = if_resp_fire;
        if (if_resp_fire) begin
          disc_nxt = disc_q - CNT_W'(1);
          if (disc_q == CNT_W'(1))
            state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if_block       = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ack)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state, counters and latched target
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      outst_q  <= '0;
      disc_q   <= '0;
      target_q <= '0;
    end else begin
      state    <= state_nxt;
      outst_q  <= outst_nxt;
      disc_q   <= disc_nxt;
      target_q <= target_nxt;
    end
  end

  assign redirect_pc = redirect_valid
                     ? target_q : 32'd0;
  assign busy        = (state != ST_IDLE);
  assign outst_cnt   = outst_q;

endmodule
